// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_bit_add_cell.sv
// Combinational 1-bit full adder built from two half-add stages and an OR.
module bit_add_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1_s;
    logic hc1_s;
    logic hc2_s;

    // Two cascaded half adders; their carries can never both be set.
    always_comb begin
        hs1_s = a ^ b;
        hc1_s = a & b;
        s     = hs1_s ^ ci;
        hc2_s = hs1_s & ci;
        co    = hc1_s | hc2_s;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared add cell walks the operands LSB-first.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_d;
    logic             cell_s_s;
    logic             cell_co_s;

    bit_add_cell u_cell (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (cell_s_s),
        .co (cell_co_s)
    );

    // Next values for one serial step; shifts stay legal even when WIDTH is 1.
    always_comb begin
        a_d            = a_q >> 1'b1;
        b_d            = b_q >> 1'b1;
        sum_d          = sum_q >> 1'b1;
        sum_d[WIDTH-1] = cell_s_s;
        cnt_d          = cnt_q + CW'(1);
    end

    // Controller FSM with its datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= cell_co_s;
                    cnt_q   <= cnt_d;
                    if (cnt_q == LAST_BIT) begin
                        cout_q  <= cell_co_s;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        start_ready = (state_q == IDLE);
        res_valid   = (state_q == DONE);
        busy        = (state_q == RUN) || (state_q == DONE);
        sum         = sum_q;
        cout        = cout_q;
    end

endmodule
